// File: rtl/filter2d_pkg.sv
// rtl/filter2d_pkg.sv - shared types and defaults for the filter2d sequencer
package filter2d_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_LOAD
  } state_e;

  localparam int NTAP_DEF = 9;
  localparam int DW_DEF   = 8;

endpackage

// File: rtl/filter2d_coef_bank.sv
// rtl/filter2d_coef_bank.sv - host-written shadow kernel, sync write, async read
module filter2d_coef_bank
  import filter2d_pkg::*;
#(
  parameter int NTAP = NTAP_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [3:0]    widx_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [3:0]    ridx_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] tap_q [NTAP];

  // Out-of-range indices are dropped on write and read back as zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAP; i++) tap_q[i] <= '0;
    end else if (we_i && ({28'd0, widx_i} < NTAP)) begin
      tap_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = ({28'd0, ridx_i} < NTAP) ? tap_q[ridx_i] : '0;

endmodule

// File: rtl/filter2d_seq_ctrl.sv
// rtl/filter2d_seq_ctrl.sv - frame sequencer and boundary-only kernel loader for filter2d
module filter2d_seq_ctrl
  import filter2d_pkg::*;
#(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int NTAP     = NTAP_DEF,
  parameter int DW       = DW_DEF,
  parameter int DRAIN_TO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_idx,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  input  logic          s_strb,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          f_i_strb,
  output logic [DW-1:0] f_i_data,
  input  logic          f_o_strb,
  output logic          f_h_write,
  output logic [3:0]    f_h_idx,
  output logic [DW-1:0] f_h_data,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int TW   = $clog2(DRAIN_TO + 1);
  localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
  localparam logic [TW-1:0] DTO_C    = TW'(DRAIN_TO);
  localparam logic [3:0]    LAST_TAP = 4'(NTAP - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          pending_q, pending_d, relatch_q, relatch_d;
  logic [3:0]    tap_q, tap_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          err_q, err_d;
  logic          fi_strb_q;
  logic [DW-1:0] fi_data_q;
  logic          pend_now, accept;

  // A commit arriving this cycle counts as pending so a boundary decision never misses it
  assign pend_now  = pending_q | cfg_commit;
  assign s_ready   = (state_q == S_RUN) | ((state_q == S_IDLE) & ~pend_now);
  assign accept    = s_strb & s_ready;
  assign cfg_busy  = (state_q == S_LOAD);
  assign f_h_write = (state_q == S_LOAD);
  assign f_h_idx   = tap_q;

  assign f_i_strb   = fi_strb_q;
  assign f_i_data   = fi_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;

  filter2d_coef_bank #(.NTAP(NTAP), .DW(DW)) u_bank (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (cfg_we & ~cfg_busy),
    .widx_i (cfg_idx),
    .wdata_i(cfg_data),
    .ridx_i (tap_q),
    .rdata_o(f_h_data)
  );

  // Next-state logic: frame sequencing, pixel/output counting, kernel load stepping
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    pending_d    = pend_now;
    relatch_d    = relatch_q;
    tap_d        = tap_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (f_o_strb) err_d = 1'b1;
        if (pend_now) begin
          state_d = S_LOAD;
          tap_d   = '0;
        end else if (accept) begin
          in_cnt_d  = CW'(1);
          out_cnt_d = '0;
          state_d   = (NPIX == 1) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        idle_cnt_d = '0;
        if (f_o_strb && out_cnt_q != NPIX_C) out_cnt_d = out_cnt_q + CW'(1);
        if (accept) begin
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_cnt_q + CW'(1) == NPIX_C) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (f_o_strb) begin
          idle_cnt_d = '0;
          if (out_cnt_q != NPIX_C) out_cnt_d = out_cnt_q + CW'(1);
        end else if (idle_cnt_q != DTO_C) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
        if (out_cnt_q == NPIX_C || idle_cnt_q == DTO_C) begin
          if (out_cnt_q != NPIX_C) err_d = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          idle_cnt_d   = '0;
          tap_d        = '0;
          state_d      = pend_now ? S_LOAD : S_IDLE;
        end
      end
      S_LOAD: begin
        if (f_o_strb) err_d = 1'b1;
        relatch_d = relatch_q | cfg_commit;
        if (tap_q == LAST_TAP) begin
          pending_d = relatch_q | cfg_commit;
          relatch_d = 1'b0;
          tap_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the registered pixel pass-through
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      pending_q    <= 1'b0;
      relatch_q    <= 1'b0;
      tap_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      fi_strb_q    <= 1'b0;
      fi_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      pending_q    <= pending_d;
      relatch_q    <= relatch_d;
      tap_q        <= tap_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      fi_strb_q    <= accept;
      fi_data_q    <= accept ? s_data : '0;
    end
  end

endmodule

// File: tb/tb_filter2d_seq_ctrl.sv
// tb/tb_filter2d_seq_ctrl.sv - directed self-checking bench for filter2d_seq_ctrl
module tb_filter2d_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we, cfg_commit, s_strb, f_o_strb;
  logic [3:0]  cfg_idx;
  logic [7:0]  cfg_data, s_data;
  logic        cfg_busy, s_ready, f_i_strb, f_h_write, frame_done, err;
  logic [7:0]  f_i_data, f_h_data;
  logic [3:0]  f_h_idx;
  logic [15:0] frame_cnt;

  filter2d_seq_ctrl #(.IMG_W(4), .IMG_H(4), .NTAP(9), .DW(8), .DRAIN_TO(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .s_strb(s_strb), .s_data(s_data),
    .s_ready(s_ready), .f_i_strb(f_i_strb), .f_i_data(f_i_data), .f_o_strb(f_o_strb),
    .f_h_write(f_h_write), .f_h_idx(f_h_idx), .f_h_data(f_h_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err(err)
  );

  // filter model: echoes each input strobe 3 cycles later, optionally dropping the 16th
  logic [2:0] pipe_q;
  int         echo_cnt;
  bit         drop_last = 1'b0;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rst) begin
      pipe_q   <= '0;
      echo_cnt <= 0;
    end else begin
      pipe_q <= {pipe_q[1:0], f_i_strb};
      if (frame_done) echo_cnt <= 0;
      else if (pipe_q[2]) echo_cnt <= echo_cnt + 1;
    end
  end
  assign f_o_strb = pipe_q[2] & ~(drop_last & (echo_cnt == 15));

  // monitor: kernel writes and last filter output
  typedef struct {int c; logic [3:0] idx; logic [7:0] d;} hw_t;
  hw_t hw_q[$];
  int  last_o = -1;
  int  busy_ready_bad = 0;
  always @(negedge clk) begin
    #2;
    if (f_h_write) begin
      hw_q.push_back('{c: cyc, idx: f_h_idx, d: f_h_data});
      if (s_ready || !cfg_busy) busy_ready_bad++;
    end
    if (f_o_strb) last_o = cyc;
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_pixel(input logic [7:0] v, input int gap);
    int w = 0;
    @(negedge clk); s_strb = 1'b1; s_data = v; #1;
    while (!s_ready && w < 50) begin @(negedge clk); #1; w++; end
    if (!s_ready) begin
      check("accept_timeout", 0, 1);
      s_strb = 1'b0;
    end else begin
      @(negedge clk); s_strb = 1'b0; s_data = '0; #1;
      check("fi_strb", f_i_strb, 1);
      check("fi_data", f_i_data, v);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_fd(input int budget, output int fdc);
    int w = 0;
    fdc = -1;
    @(negedge clk); #1;
    while (!frame_done && w < budget) begin @(negedge clk); #1; w++; end
    if (frame_done) fdc = cyc;
    else check("frame_done_timeout", 0, 1);
  endtask

  task automatic check_load(input int base, input int first_c, input bit zero);
    for (int k = 0; k < 9; k++) begin
      if (base + k < hw_q.size()) begin
        check("load_cyc", hw_q[base+k].c, first_c + k);
        check("load_idx", hw_q[base+k].idx, k);
        check("load_data", hw_q[base+k].d, zero ? 0 : (8'h10 + k));
      end else begin
        check("load_missing", 0, 1);
      end
    end
  endtask

  int fdc, c0, acc, w, early;

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_commit = 0; cfg_idx = 0; cfg_data = 0; s_strb = 0; s_data = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_fi_strb", f_i_strb, 0);
    check("rst_h_write", f_h_write, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_err", err, 0);

    // 1: one frame of 16 pixels with long gaps
    for (int p = 1; p <= 16; p++) send_pixel(8'(p), (p == 16) ? 0 : 15);
    wait_fd(40, fdc);
    check("t1_fd_lat", fdc - last_o, 2);
    @(negedge clk); #1;
    check("t1_fd_pulse", frame_done, 0);
    check("t1_fcnt", frame_cnt, 1);
    check("t1_err", err, 0);

    // 2: taps written, commit mid-frame, load only at the boundary
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); cfg_we = 1; cfg_idx = 4'(k); cfg_data = 8'(8'h10 + k);
    end
    @(negedge clk); cfg_we = 0;
    hw_q.delete(); busy_ready_bad = 0;
    for (int p = 1; p <= 16; p++) begin
      send_pixel(8'(8'h20 + p), (p == 16) ? 0 : 2);
      if (p == 5) begin
        @(negedge clk); cfg_commit = 1;
        @(negedge clk); cfg_commit = 0;
      end
    end
    wait_fd(40, fdc);
    check("t2_no_early_hw", hw_q.size(), 0);
    repeat (11) @(negedge clk);
    #3;
    check("t2_load_len", hw_q.size(), 9);
    check_load(0, fdc, 0);
    check("t2_ready_busy", busy_ready_bad, 0);
    check("t2_fcnt", frame_cnt, 2);

    // 3: commit in IDLE with a pixel waiting -> LOAD wins, pixel follows
    hw_q.delete();
    @(negedge clk); cfg_commit = 1; s_strb = 1; s_data = 8'h55; #1;
    c0 = cyc;
    check("t3_not_ready", s_ready, 0);
    @(negedge clk); cfg_commit = 0; #1;
    w = 0; early = 0;
    while (!s_ready && w < 20) begin
      if (f_i_strb) early++;
      @(negedge clk); #1; w++;
    end
    acc = cyc;
    check("t3_acc_cyc", acc, c0 + 10);
    check("t3_no_early_pix", early, 0);
    @(negedge clk); s_strb = 0; s_data = 0; #1;
    check("t3_fi_strb", f_i_strb, 1);
    check("t3_fi_data", f_i_data, 8'h55);
    #2;
    check("t3_load_len", hw_q.size(), 9);
    check_load(0, c0 + 1, 0);

    // 4: last output dropped -> drain timeout
    drop_last = 1'b1;
    for (int p = 2; p <= 16; p++) send_pixel(8'(p), 0);
    wait_fd(60, fdc);
    check("t4_timeout_lat", fdc - last_o, 10);
    check("t4_err", err, 1);
    @(negedge clk); #1;
    drop_last = 1'b0;
    check("t4_fcnt", frame_cnt, 3);
    check("t4_fd_pulse", frame_done, 0);

    // 6: ignored writes (index out of range, busy) and a commit re-latched during LOAD
    hw_q.delete();
    @(negedge clk); cfg_we = 1; cfg_idx = 4'd9; cfg_data = 8'hEE;
    @(negedge clk); cfg_we = 0; cfg_commit = 1; #1;
    c0 = cyc;
    @(negedge clk); cfg_commit = 0;
    repeat (2) @(negedge clk);
    cfg_we = 1; cfg_idx = 4'd2; cfg_data = 8'hAA; cfg_commit = 1; #1;
    check("t6_busy", cfg_busy, 1);
    @(negedge clk); cfg_we = 0; cfg_commit = 0;
    repeat (20) @(negedge clk);
    #3;
    check("t6_two_loads", hw_q.size(), 18);
    check_load(0, c0 + 1, 0);
    check_load(9, c0 + 11, 0);

    // 5: reset in the middle of a LOAD
    hw_q.delete();
    @(negedge clk); cfg_commit = 1;
    @(negedge clk); cfg_commit = 0; #1;
    w = 0;
    while (!(f_h_write && f_h_idx == 4'd4) && w < 20) begin @(negedge clk); #1; w++; end
    check("t5_reach_tap4", f_h_idx, 4);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t5_h_write", f_h_write, 0);
    check("t5_busy", cfg_busy, 0);
    check("t5_s_ready", s_ready, 1);
    check("t5_fcnt", frame_cnt, 0);
    check("t5_err", err, 0);
    rst = 1'b0;
    #2;
    hw_q.delete();
    @(negedge clk); cfg_commit = 1; #1;
    c0 = cyc;
    @(negedge clk); cfg_commit = 0;
    repeat (12) @(negedge clk);
    #3;
    check("t5_load_len", hw_q.size(), 9);
    check_load(0, c0 + 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
